time_uart_tx: RTL and testbench

// - Downstream consumer of the time-of-day counter: on request, snapshots hours/minutes/seconds
//   and transmits them as the ASCII line "HH:MM:SS\r\n" over an 8N1 UART TX pin.
// - Sits between the clock block's binary outputs and the board TX pad. Its only handshake is

---
 rtl/time_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_time_uart_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_uart_tx.sv
// Snapshots hours/minutes/seconds on request and sends "HH:MM:SS\r\n" as 8N1 UART on tx.
// Optional macro TIME_UART_AUTO_EN: a change of the seconds input also requests a message.
module time_uart_tx #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [3:0]    char_idx;
    logic [5:0]    snap_h, snap_m, snap_s;
    logic [7:0]    cur_char;
    logic          bit_end;
    logic          start_req;

    // Comparator chain instead of a divider; values above 59 still map to tens=6.
    function automatic logic [2:0] tens_of(input logic [5:0] v);
        if (v >= 6'd60)      return 3'd6;
        else if (v >= 6'd50) return 3'd5;
        else if (v >= 6'd40) return 3'd4;
        else if (v >= 6'd30) return 3'd3;
        else if (v >= 6'd20) return 3'd2;
        else if (v >= 6'd10) return 3'd1;
        else                 return 3'd0;
    endfunction

    function automatic logic [7:0] ascii_tens(input logic [5:0] v);
        return 8'h30 + {5'd0, tens_of(v)};
    endfunction

    function automatic logic [7:0] ascii_ones(input logic [5:0] v);
        logic [5:0] r;
        r = v - ({3'd0, tens_of(v)} * 6'd10);
        return 8'h30 + {2'd0, r};
    endfunction

    always_comb begin
        cur_char = 8'h0A;
        case (char_idx)
            4'd0:    cur_char = ascii_tens(snap_h);
            4'd1:    cur_char = ascii_ones(snap_h);
            4'd2:    cur_char = 8'h3A;
            4'd3:    cur_char = ascii_tens(snap_m);
            4'd4:    cur_char = ascii_ones(snap_m);
            4'd5:    cur_char = 8'h3A;
            4'd6:    cur_char = ascii_tens(snap_s);
            4'd7:    cur_char = ascii_ones(snap_s);
            4'd8:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    assign bit_end = (baud_cnt == BAUD_LAST);

`ifdef TIME_UART_AUTO_EN
    logic [5:0] prev_sec;
    logic       primed;
    logic       pending;
    logic       sec_chg;

    // primed suppresses a trigger on the first cycle after reset
    assign sec_chg   = primed && (seconds != prev_sec);
    assign start_req = send || sec_chg || pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_sec <= 6'd0;
            primed   <= 1'b0;
            pending  <= 1'b0;
        end else begin
            prev_sec <= seconds;
            primed   <= 1'b1;
            if (state == IDLE)
                pending <= 1'b0;
            else if (sec_chg)
                pending <= 1'b1;
        end
    end
`else
    assign start_req = send;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            char_idx <= 4'd0;
            snap_h   <= 6'd0;
            snap_m   <= 6'd0;
            snap_s   <= 6'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        snap_h   <= hours;
                        snap_m   <= minutes;
                        snap_s   <= seconds;
                        char_idx <= 4'd0;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        tx       <= cur_char[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_char[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (char_idx == 4'd9) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // next start bit follows the stop bit with no idle gap
                            char_idx <= char_idx + 4'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_uart_tx.sv
// Scoreboard bench for time_uart_tx: expected bytes are queued by stimulus, a mid-bit UART
// monitor pops and compares each received byte. Define TIME_UART_AUTO_EN to cover auto mode.
module tb_time_uart_tx;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] hours = 6'd0, minutes = 6'd0, seconds = 6'd0;
    logic       send = 1'b0;
    logic       tx, busy, done;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    time_uart_tx #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .hours(hours), .minutes(minutes), .seconds(seconds),
        .send(send), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!reset && done) done_cnt++;

    function automatic void check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    task automatic push_msg(input logic [79:0] s);
        for (int i = 9; i >= 0; i--) exp_q.push_back(s[i*8 +: 8]);
    endtask

    // UART monitor: frame counted from the first low sample; data bits sampled mid-bit
    int       mcnt = 0;
    logic     mact = 1'b0;
    logic [7:0] mbyte = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (!tx) begin
                mact = 1'b1;
                mcnt = 0;
            end
        end else begin
            mcnt++;
            if (mcnt == 2) check("start_bit", int'(tx), 0);
            if (mcnt >= 6 && mcnt <= 34 && ((mcnt - 6) % 4) == 0) mbyte[(mcnt-6)/4] = tx;
            if (mcnt == 38) begin
                check("stop_bit", int'(tx), 1);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", mbyte);
                end else begin
                    check("byte", int'(mbyte), int'(exp_q.pop_front()));
                end
            end
            if (mcnt == 39) mact = 1'b0;
        end
    end

    task automatic do_reset(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        @(negedge clk);
        reset = 1'b1;
        hours = h; minutes = m; seconds = s;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_send(output int t0);
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("busy_rise", int'(busy), 1);
        check("tx_fall", int'(tx), 0);
        t0 = cyc;
    endtask

    // returns at the negedge after the done cycle
    task automatic wait_done(input int t0);
        bit seen = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 1000 cycles");
        end else begin
            check("done_latency", cyc - t0, 100 * B);
            check("busy_at_done", int'(busy), 0);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
        end
    endtask

    initial begin
        int t0, t1, dc;
        bit busy_drop;

        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;

        // basic message and boundary values
        do_reset(6'd13, 6'd5, 6'd59);
        push_msg("13:05:59\r\n");
        pulse_send(t0);
        wait_done(t0);

        do_reset(6'd0, 6'd0, 6'd0);
        push_msg("00:00:00\r\n");
        pulse_send(t0);
        wait_done(t0);

        do_reset(6'd63, 6'd63, 6'd63);
        push_msg("63:63:63\r\n");
        pulse_send(t0);
        wait_done(t0);

        // snapshot freeze: input change and second send during the message
        do_reset(6'd12, 6'd34, 6'd10);
        push_msg("12:34:10\r\n");
        pulse_send(t0);
        busy_drop = 1'b0;
        for (int i = 1; i < 100 * B; i++) begin
            @(negedge clk);
            if (i == 4)  seconds = 6'd11;
            if (i == 19) send = 1'b1;
            if (i == 20) send = 1'b0;
            if (!busy) busy_drop = 1'b1;
        end
        check("busy_held", int'(busy_drop), 0);
        wait_done(t0);
`ifdef TIME_UART_AUTO_EN
        push_msg("12:34:11\r\n");
        check("pending_start", int'(busy), 1);
        t0 = cyc;
        wait_done(t0);
`else
        dc = done_cnt;
        repeat (50) @(negedge clk);
        check("no_queued_send", int'(busy), 0);
        check("no_extra_done", done_cnt - dc, 0);
`endif

        // back-to-back with send held high
        do_reset(6'd1, 6'd2, 6'd3);
        push_msg("01:02:03\r\n");
        push_msg("01:02:03\r\n");
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        check("b2b_busy", int'(busy), 1);
        t0 = cyc;
        wait_done(t0);
        check("b2b_restart_busy", int'(busy), 1);
        check("b2b_restart_tx", int'(tx), 0);
        t1 = cyc;
        send = 1'b0;
        wait_done(t1);
        check("b2b_idle", int'(busy), 0);

        // reset mid-frame at char 3, data bit 4
        do_reset(6'd13, 6'd5, 6'd59);
        push_msg("13:05:59\r\n");
        pulse_send(t0);
        repeat (142) @(negedge clk);
        dc = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (450) @(negedge clk);
        check("abort_no_done", done_cnt - dc, 0);
        push_msg("13:05:59\r\n");
        pulse_send(t0);
        wait_done(t0);

`ifdef TIME_UART_AUTO_EN
        do_reset(6'd10, 6'd20, 6'd5);
        repeat (5) @(negedge clk);
        check("auto_no_spurious", int'(busy), 0);
        dc = done_cnt;
        push_msg("10:20:06\r\n");
        seconds = 6'd6;
        @(negedge clk);
        check("auto_start", int'(busy), 1);
        t0 = cyc;
        repeat (50) @(negedge clk);
        seconds = 6'd7;
        repeat (50) @(negedge clk);
        seconds = 6'd8;
        push_msg("10:20:08\r\n");
        wait_done(t0);
        check("auto_pending_busy", int'(busy), 1);
        check("auto_pending_tx", int'(tx), 0);
        t1 = cyc;
        wait_done(t1);
        repeat (200) @(negedge clk);
        check("auto_idle", int'(busy), 0);
        check("auto_done_count", done_cnt - dc, 2);
`else
        do_reset(6'd10, 6'd20, 6'd5);
        seconds = 6'd6;
        repeat (20) @(negedge clk);
        check("no_auto_trigger", int'(busy), 0);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
